// File: rtl/bla_sub_clk_pkg.sv
// Shared definitions for the nibble-serial subtractor.
package bla_sub_clk_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

endpackage

// File: rtl/_and2.sv
// 2-input AND gate primitive.
module _and2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

// File: rtl/_and3.sv
// 3-input AND gate primitive.
module _and3 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);
  assign y_o = a_i & b_i & c_i;
endmodule

// File: rtl/_and4.sv
// 4-input AND gate primitive.
module _and4 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic y_o
);
  assign y_o = a_i & b_i & c_i & d_i;
endmodule

// File: rtl/_and5.sv
// 5-input AND gate primitive.
module _and5 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  input  logic e_i,
  output logic y_o
);
  assign y_o = a_i & b_i & c_i & d_i & e_i;
endmodule

// File: rtl/_or2.sv
// 2-input OR gate primitive.
module _or2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/_or3.sv
// 3-input OR gate primitive.
module _or3 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);
  assign y_o = a_i | b_i | c_i;
endmodule

// File: rtl/_or4.sv
// 4-input OR gate primitive.
module _or4 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic y_o
);
  assign y_o = a_i | b_i | c_i | d_i;
endmodule

// File: rtl/_or5.sv
// 5-input OR gate primitive.
module _or5 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  input  logic e_i,
  output logic y_o
);
  assign y_o = a_i | b_i | c_i | d_i | e_i;
endmodule

// File: rtl/bla_sub_clk_bls4.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - bi.
// Borrow generate g = ~a & b, propagate p = ~a | b; every borrow is a flat
// two-level sum of products so no borrow ripples through another.
module bla_sub_clk_bls4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic [3:0] d,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic       t10;
  logic       t20, t21;
  logic       t30, t31, t32;
  logic       t40, t41, t42, t43;

  assign g = ~a & b;
  assign p = ~a | b;

  // b1 = g0 | p0.bi
  _and2 u_t10 (.a_i(p[0]), .b_i(bi), .y_o(t10));
  _or2  u_b1  (.a_i(g[0]), .b_i(t10), .y_o(b1));

  // b2 = g1 | p1.g0 | p1.p0.bi
  _and2 u_t20 (.a_i(p[1]), .b_i(g[0]), .y_o(t20));
  _and3 u_t21 (.a_i(p[1]), .b_i(p[0]), .c_i(bi), .y_o(t21));
  _or3  u_b2  (.a_i(g[1]), .b_i(t20), .c_i(t21), .y_o(b2));

  // b3 = g2 | p2.g1 | p2.p1.g0 | p2.p1.p0.bi
  _and2 u_t30 (.a_i(p[2]), .b_i(g[1]), .y_o(t30));
  _and3 u_t31 (.a_i(p[2]), .b_i(p[1]), .c_i(g[0]), .y_o(t31));
  _and4 u_t32 (.a_i(p[2]), .b_i(p[1]), .c_i(p[0]), .d_i(bi), .y_o(t32));
  _or4  u_b3  (.a_i(g[2]), .b_i(t30), .c_i(t31), .d_i(t32), .y_o(b3));

  // bo = g3 | p3.g2 | p3.p2.g1 | p3.p2.p1.g0 | p3.p2.p1.p0.bi
  _and2 u_t40 (.a_i(p[3]), .b_i(g[2]), .y_o(t40));
  _and3 u_t41 (.a_i(p[3]), .b_i(p[2]), .c_i(g[1]), .y_o(t41));
  _and4 u_t42 (.a_i(p[3]), .b_i(p[2]), .c_i(p[1]), .d_i(g[0]), .y_o(t42));
  _and5 u_t43 (.a_i(p[3]), .b_i(p[2]), .c_i(p[1]), .d_i(p[0]), .e_i(bi), .y_o(t43));
  _or5  u_bo  (.a_i(g[3]), .b_i(t40), .c_i(t41), .d_i(t42), .e_i(t43), .y_o(bo));

  assign d = a ^ b ^ {b3, b2, b1, bi};

endmodule

// File: rtl/bla_sub_clk.sv
// Sequential WIDTH-bit subtractor: D = A - B - Bi, one nibble per clock.
module bla_sub_clk
  import bla_sub_clk_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bi,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bo,
  output logic             o_ovf
);

  localparam int unsigned N       = WIDTH / NIBBLE;
  localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             bor_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             ovf_q;

  logic [3:0]       nib_d;
  logic             nib_bo;
  logic             nib_b1, nib_b2, nib_b3;
  logic             unused_borrows;

  // Operand registers shift right each RUN cycle, so the slice always sees nibble 0.
  bla_sub_clk_bls4 u_bls4 (
    .a  (a_q[NIBBLE-1:0]),
    .b  (b_q[NIBBLE-1:0]),
    .bi (bor_q),
    .d  (nib_d),
    .b1 (nib_b1),
    .b2 (nib_b2),
    .b3 (nib_b3),
    .bo (nib_bo)
  );

  assign unused_borrows = nib_b1 ^ nib_b2 ^ nib_b3;

  // Control FSM with registered outputs; DONE accepts a new start like IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bor_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_b;
            bor_q   <= i_bi;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          d_q[idx_q*NIBBLE +: NIBBLE] <= nib_d;
          bor_q <= nib_bo;
          a_q   <= a_q >> NIBBLE;
          b_q   <= b_q >> NIBBLE;
          idx_q <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            // The top nibble's bit 3 is the operand sign bit.
            bo_q    <= nib_bo;
            ovf_q   <= (a_q[3] != b_q[3]) && (nib_d[3] != a_q[3]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_d    = d_q;
  assign o_bo   = bo_q;
  assign o_ovf  = ovf_q;

endmodule
